counter_ctrl: RTL and testbench

Run controller for the 4-bit `counter` datapath. Accepts a target-count command over a valid/ready handshake, clears the counter, drives its `enable` until the count reaches the target, and honours pause and abort. It sits between a command source and one `counter` instance, driving that instance's `reset` and `enable` and observing its `count`.

---
 rtl/counter_ctrl_pkg.sv | 15 +
 rtl/counter_ctrl_if.sv | 30 +++
 rtl/counter.sv | 37 +++
 rtl/counter_ctrl.sv | 115 +++++++++++
 tb/tb_counter_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter run controller.
//   DEFAULT_WIDTH : default counter width (must match the driven counter)
//   ctrl_state_t  : controller state encoding, also exported for debug
package counter_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/counter_ctrl_if.sv
// Command channel into the counter run controller.
//   cmd_valid  : source -> controller, a command is present
//   cmd_ready  : controller -> source, controller can accept a command
//   cmd_target : source -> controller, count to stop at
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. Once raised, cmd_valid and cmd_target stay
// stable until that transfer; cmd_ready never depends on cmd_valid.
interface counter_ctrl_if
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_target;

    modport master (
        output cmd_valid,
        output cmd_target,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_target,
        output cmd_ready
    );

endinterface

// File: rtl/counter.sv
// Plain up-counter datapath driven by counter_ctrl.
//   clk    : rising-edge clock
//   reset  : asynchronous active-high clear of count
//   enable : increment count on the next edge
//   count  : current count value
module counter
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/counter_ctrl.sv
// Run controller for one counter instance. Accepts a target count, clears
// the counter for one cycle, enables it until it reaches the target, then
// pulses done. Pause suspends counting; abort ends the run early.
//   clk, reset : clock and asynchronous active-high reset
//   cmd        : command channel (slave side), see counter_ctrl_if
//   pause      : level, suspends counting while in RUN
//   abort      : single-cycle request to end a run in CLEAR or RUN
//   cnt_reset  : registered, drives the counter's asynchronous reset
//   cnt_enable : drives the counter's enable
//   cnt_value  : the counter's current count
//   busy       : high in CLEAR and RUN
//   done       : one-cycle pulse on normal completion
//   aborted    : one-cycle pulse when a run is ended by abort
//   dbg_state  : current controller state
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    counter_ctrl_if.slave    cmd,
    input  logic             pause,
    input  logic             abort,
    output logic             cnt_reset,
    output logic             cnt_enable,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output ctrl_state_t      dbg_state
);

    ctrl_state_t      state_q,     state_d;
    logic [WIDTH-1:0] target_q,    target_d;
    logic             cnt_reset_q, cnt_reset_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic             aborted_q,   aborted_d;

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        aborted_d = 1'b0;
        case (state_q)
            IDLE: begin
                // cmd_ready is high whenever we are in IDLE out of reset.
                if (cmd.cmd_valid) begin
                    target_d = cmd.cmd_target;
                    state_d  = CLEAR;
                end
            end
            CLEAR: begin
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Abort takes priority over reaching the target.
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (cnt_value == target_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outputs are decoded from the next state so they leave a flop
        // aligned with the state they belong to; cnt_reset in particular
        // feeds an asynchronous reset and must be glitch-free.
        cnt_reset_d = (state_d == CLEAR);
        busy_d      = (state_d == CLEAR) || (state_d == RUN);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            target_q    <= '0;
            cnt_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            cnt_reset_q <= cnt_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    // Abort also gates the enable so the count freezes in the cycle the
    // abort is requested, not one cycle later.
    assign cnt_enable = (state_q == RUN) && !pause && !abort
                        && (cnt_value != target_q);

    assign cmd.cmd_ready = (state_q == IDLE) && !reset;
    assign cnt_reset     = cnt_reset_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign aborted       = aborted_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
module tb_counter_ctrl;
    import counter_ctrl_pkg::*;

    localparam int W  = DEFAULT_WIDTH;
    localparam int EW = 21;      // {is_abort, final count[3:0], end cycle[15:0]}
    localparam int NO = 1000;    // "no abort" index

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        pause;
    logic        abort;
    logic        cnt_reset;
    logic        cnt_enable;
    logic [W-1:0] cnt_value;
    logic        busy;
    logic        done;
    logic        aborted;
    ctrl_state_t dbg_state;

    counter_ctrl_if #(.WIDTH(W)) cif ();

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    counter_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (cif),
        .pause      (pause),
        .abort      (abort),
        .cnt_reset  (cnt_reset),
        .cnt_enable (cnt_enable),
        .cnt_value  (cnt_value),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .dbg_state  (dbg_state)
    );

    counter #(.WIDTH(W)) u_counter (
        .clk    (clk),
        .reset  (cnt_reset),
        .enable (cnt_enable),
        .count  (cnt_value)
    );

    // ---------------- scoreboard state ----------------
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int          cur_target = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Walks the run cycle by cycle: the count advances by one in every
    // un-paused cycle until it equals the target; the cycle in which it
    // equals the target is followed by the done cycle. An abort in a run
    // cycle ends the run in the following cycle with the count frozen.
    // off = offset of the pulse cycle from the accept edge (CLEAR is 1).
    function automatic void model_run(input int t, input logic [63:0] pm, input int a,
                                      output bit is_ab, output int off, output int fin);
        int c;
        c = 0;
        is_ab = 1'b0;
        off = 0;
        fin = 0;
        if (a == -1) begin
            is_ab = 1'b1;
            off = 2;
            fin = 0;
            return;
        end
        for (int i = 0; i < 200; i++) begin
            if (i == a) begin
                is_ab = 1'b1;
                off = 3 + i;
                fin = c;
                return;
            end
            if (c == t) begin
                off = 3 + i;
                fin = t;
                return;
            end
            if (!(i < 64 && pm[i])) c++;
        end
    endfunction

    function automatic int count_at(input int t, input logic [63:0] pm, input int idx);
        int c;
        c = 0;
        for (int j = 0; j < idx; j++) begin
            if (c != t && !(j < 64 && pm[j])) c++;
        end
        return c;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                if (done || aborted) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_pulse",    int'(done),      int'(!e[20]));
                        check("aborted_pulse", int'(aborted),   int'(e[20]));
                        check("end_cycle",     cyc,             int'(e[15:0]));
                        check("final_count",   int'(cnt_value), int'(e[19:16]));
                    end
                end
                if (cnt_enable) begin
                    check("enable_legal",
                          (pause || abort || int'(cnt_value) == cur_target || dbg_state != RUN) ? 1 : 0,
                          0);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_cmd(input int t, input logic [63:0] pm, input int a, input int rst_at);
        bit   is_ab;
        int   off;
        int   fin;
        int   n_edge;
        int   waited;
        logic [15:0] end_cyc;
        model_run(t, pm, a, is_ab, off, fin);
        waited = 0;
        @(negedge clk);
        while (!cif.cmd_ready && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (!cif.cmd_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        cif.cmd_valid  = 1'b1;
        cif.cmd_target = t[W-1:0];
        cur_target     = t;
        @(posedge clk);
        #1;
        n_edge  = cyc;
        end_cyc = 16'(n_edge + off - 1);
        if (rst_at < 0) exp_q.push_back({is_ab, fin[W-1:0], end_cyc});
        @(negedge clk);                       // CLEAR cycle
        cif.cmd_valid = 1'b0;
        abort = (a == -1);
        check("clear_cnt_reset", int'(cnt_reset),     1);
        check("clear_busy",      int'(busy),          1);
        check("clear_ready",     int'(cif.cmd_ready), 0);
        for (int i = 0; i <= off - 2; i++) begin
            @(negedge clk);
            pause = (i < 64) ? pm[i] : 1'b0;
            abort = (a == i);
            if (i == rst_at) begin
                #2 reset = 1'b1;
                #1;
                check("rst_ready",      int'(cif.cmd_ready), 0);
                check("rst_cnt_reset",  int'(cnt_reset),     0);
                check("rst_cnt_enable", int'(cnt_enable),    0);
                check("rst_busy",       int'(busy),          0);
                check("rst_done",       int'(done),          0);
                check("rst_aborted",    int'(aborted),       0);
                check("rst_state",      int'(dbg_state),     int'(IDLE));
                check("rst_cnt_kept",   int'(cnt_value),     count_at(t, pm, i));
                @(negedge clk);
                reset = 1'b0;
                pause = 1'b0;
                abort = 1'b0;
                #1;
                check("ready_after_reset", int'(cif.cmd_ready), 1);
                return;
            end
        end
        // Now in the pulse cycle: IDLE after abort, DONE otherwise.
        check("ready_at_end", int'(cif.cmd_ready), int'(is_ab));
        pause = 1'b0;
        abort = 1'b0;
        if (!is_ab) begin
            @(negedge clk);
            check("ready_after_done", int'(cif.cmd_ready), 1);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          t;
        int          a;
        logic [63:0] pm;
        reset = 1'b1;
        pause = 1'b0;
        abort = 1'b0;
        cif.cmd_valid  = 1'b0;
        cif.cmd_target = '0;
        repeat (2) @(negedge clk);
        check("reset_ready",      int'(cif.cmd_ready), 0);
        check("reset_cnt_reset",  int'(cnt_reset),     0);
        check("reset_cnt_enable", int'(cnt_enable),    0);
        check("reset_busy",       int'(busy),          0);
        check("reset_done",       int'(done),          0);
        check("reset_aborted",    int'(aborted),       0);
        reset = 1'b0;
        #1;
        check("ready_out_of_reset", int'(cif.cmd_ready), 1);
        check("state_out_of_reset", int'(dbg_state), int'(IDLE));

        run_cmd(5,  64'h0,  NO, -1);   // plain run, done 8 cycles after accept
        run_cmd(5,  64'h1C, NO, -1);   // pause in 3rd..5th RUN cycles, done at +11
        run_cmd(0,  64'h0,  NO, -1);   // target 0, done at +3
        run_cmd(15, 64'h0,  NO, -1);   // all-ones target, no wrap
        run_cmd(9,  64'h0,  3,  -1);   // abort while count is 3
        run_cmd(2,  64'h0,  NO, -1);   // clean run after abort
        run_cmd(9,  64'h0,  NO, 4);    // async reset mid-run
        run_cmd(3,  64'h0,  NO, -1);   // normal run after reset
        run_cmd(4,  64'h0,  -1, -1);   // abort during CLEAR
        run_cmd(3,  64'h0,  3,  -1);   // abort on the target cycle wins
        run_cmd(6,  64'h0,  7,  -1);   // abort in DONE is ignored
        run_cmd(4,  64'hFF, NO, -1);   // long pause from first RUN cycle

        for (int k = 0; k < 24; k++) begin
            t  = int'($urandom_range(0, 15));
            pm = {$urandom, $urandom} & {$urandom, $urandom};
            a  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, t + 4)) - 1 : NO;
            run_cmd(t, pm, a, -1);
        end

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
